// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares the single data-memory port between the pipeline memory stage
// (requester 0) and the loader/DMA port (requester 1). Conflicts are resolved
// round-robin. Each accepted access is sequenced through IDLE -> BUSY -> DONE,
// with BUSY lasting ACCESS_CYCLES cycles. The memory-side outputs are
// registered. The memory commits stores on the falling clock edge, so the
// write strobe is raised for exactly one cycle: the final BUSY cycle.
//
// Parameters
//   DATA_WIDTH     data bus width in bits
//   ACCESS_CYCLES  memory-side cycles per transaction, 1..15
//
// Ports
//   iClk, iRst                 clock, synchronous active-high reset
//   iReq*/iWe*/iSize*/iUns*    per-requester request, store flag, size, unsigned
//   iAddr*/iWData*             per-requester byte address and right-aligned data
//   oGnt0/oGnt1                one-cycle pulse: payload latched
//   oRValid0/oRValid1          one-cycle pulse: transaction complete
//   oRData/oErr                load result / misaligned-or-reserved flag
//   oMemWriteEn/oMemLoad       registered memory strobes
//   oMemSize/oMemUns/oMemAddr/oMemWData  latched payload towards memory
//   iMemRData                  combinational read data from memory
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iReq0,
  input  logic                  iReq1,
  input  logic                  iWe0,
  input  logic                  iWe1,
  input  logic [1:0]            iSize0,
  input  logic [1:0]            iSize1,
  input  logic                  iUns0,
  input  logic                  iUns1,
  input  logic [31:0]           iAddr0,
  input  logic [31:0]           iAddr1,
  input  logic [DATA_WIDTH-1:0] iWData0,
  input  logic [DATA_WIDTH-1:0] iWData1,
  output logic                  oGnt0,
  output logic                  oGnt1,
  output logic                  oRValid0,
  output logic                  oRValid1,
  output logic [DATA_WIDTH-1:0] oRData,
  output logic                  oErr,
  output logic                  oMemWriteEn,
  output logic                  oMemLoad,
  output logic [1:0]            oMemSize,
  output logic                  oMemUns,
  output logic [31:0]           oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemWData,
  input  logic [DATA_WIDTH-1:0] iMemRData
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The counter holds the number of BUSY cycles still to come after the
  // current one; 4 bits covers the 1..15 range of ACCESS_CYCLES.
  localparam logic [3:0] CNT_INIT     = 4'(ACCESS_CYCLES - 1);
  localparam logic       SINGLE_CYCLE = (ACCESS_CYCLES == 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       last_reg;   // requester served most recently
  logic       sel_reg;    // requester owning the current transaction
  logic       we_reg;
  logic       err_reg;

  // Payload of the requester that would win if a grant happened now.
  logic                  pick;
  logic                  pick_we;
  logic [1:0]            pick_size;
  logic                  pick_uns;
  logic [31:0]           pick_addr;
  logic [DATA_WIDTH-1:0] pick_wdata;
  logic                  pick_err;

  // Reserved size, or a half/word access that is not naturally aligned.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lsb[0];
      2'b10:   bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign pick       = (iReq0 && iReq1) ? ~last_reg : iReq1;
  assign pick_we    = pick ? iWe1    : iWe0;
  assign pick_size  = pick ? iSize1  : iSize0;
  assign pick_uns   = pick ? iUns1   : iUns0;
  assign pick_addr  = pick ? iAddr1  : iAddr0;
  assign pick_wdata = pick ? iWData1 : iWData0;
  assign pick_err   = bad_access(pick_size, pick_addr[1:0]);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      last_reg    <= 1'b1;  // so that requester 0 wins the first conflict
      sel_reg     <= 1'b0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
      oGnt0       <= 1'b0;
      oGnt1       <= 1'b0;
      oRValid0    <= 1'b0;
      oRValid1    <= 1'b0;
      oRData      <= '0;
      oErr        <= 1'b0;
      oMemWriteEn <= 1'b0;
      oMemLoad    <= 1'b0;
      oMemSize    <= '0;
      oMemUns     <= 1'b0;
      oMemAddr    <= '0;
      oMemWData   <= '0;
    end else begin
      // Handshake outputs are single-cycle pulses.
      oGnt0    <= 1'b0;
      oGnt1    <= 1'b0;
      oRValid0 <= 1'b0;
      oRValid1 <= 1'b0;
      oErr     <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (iReq0 || iReq1) begin
            sel_reg   <= pick;
            we_reg    <= pick_we;
            err_reg   <= pick_err;
            oGnt0     <= ~pick;
            oGnt1     <= pick;
            oMemSize  <= pick_size;
            oMemUns   <= pick_uns;
            oMemAddr  <= pick_addr;
            oMemWData <= pick_wdata;
            // Faulting accesses still occupy the BUSY slot but never touch memory.
            oMemLoad    <= ~pick_we & ~pick_err;
            // A one-cycle access makes the first BUSY cycle also the last.
            oMemWriteEn <= SINGLE_CYCLE & pick_we & ~pick_err;
            cnt_reg     <= CNT_INIT;
            state_reg   <= BUSY;
          end
        end

        BUSY: begin
          if (cnt_reg == 4'd0) begin
            oRData      <= (we_reg || err_reg) ? '0 : iMemRData;
            oMemWriteEn <= 1'b0;
            oMemLoad    <= 1'b0;
            state_reg   <= DONE;
          end else begin
            cnt_reg     <= cnt_reg - 4'd1;
            // Strobe lands in the cycle where the counter reaches zero.
            oMemWriteEn <= (cnt_reg == 4'd1) & we_reg & ~err_reg;
          end
        end

        DONE: begin
          oRValid0  <= ~sel_reg;
          oRValid1  <= sel_reg;
          oErr      <= err_reg;
          last_reg  <= sel_reg;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Two arbiter instances (ACCESS_CYCLES = 1 and 3) run side by side. Each has a
// transaction-level reference model that decides grants from the round-robin
// rule and derives every output from the cycle offset relative to the grant.
// A compare process checks all outputs against the model on every cycle.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Stimulus, indexed [instance][requester]
  logic        rst       [2];
  logic        req       [2][2];
  logic        we_in     [2][2];
  logic [1:0]  size_in   [2][2];
  logic        uns_in    [2][2];
  logic [31:0] addr_in   [2][2];
  logic [31:0] wdata_in  [2][2];
  logic [31:0] mem_rdata [2];
  bit          rd_fixed  [2];
  logic [31:0] rd_val    [2];

  // DUT outputs
  logic        gnt    [2][2];
  logic        rv     [2][2];
  logic [31:0] rdata  [2];
  logic        err    [2];
  logic        mwe    [2];
  logic        mload  [2];
  logic [1:0]  msize  [2];
  logic        muns   [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];

  task automatic chk(input int cfg, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s: got=%0h expected=%0h", cfg, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int AC = (gi == 0) ? 1 : 3;

    data_mem_arbiter #(.DATA_WIDTH(32), .ACCESS_CYCLES(AC)) u_dut (
      .iClk       (clk),
      .iRst       (rst[gi]),
      .iReq0      (req[gi][0]),
      .iReq1      (req[gi][1]),
      .iWe0       (we_in[gi][0]),
      .iWe1       (we_in[gi][1]),
      .iSize0     (size_in[gi][0]),
      .iSize1     (size_in[gi][1]),
      .iUns0      (uns_in[gi][0]),
      .iUns1      (uns_in[gi][1]),
      .iAddr0     (addr_in[gi][0]),
      .iAddr1     (addr_in[gi][1]),
      .iWData0    (wdata_in[gi][0]),
      .iWData1    (wdata_in[gi][1]),
      .oGnt0      (gnt[gi][0]),
      .oGnt1      (gnt[gi][1]),
      .oRValid0   (rv[gi][0]),
      .oRValid1   (rv[gi][1]),
      .oRData     (rdata[gi]),
      .oErr       (err[gi]),
      .oMemWriteEn(mwe[gi]),
      .oMemLoad   (mload[gi]),
      .oMemSize   (msize[gi]),
      .oMemUns    (muns[gi]),
      .oMemAddr   (maddr[gi]),
      .oMemWData  (mwdata[gi]),
      .iMemRData  (mem_rdata[gi])
    );

    // Reference model state: one outstanding transaction granted at edge t0.
    bit          armed = 1'b0;
    bit          busy  = 1'b0;
    bit          last  = 1'b1;
    bit          sel   = 1'b0;
    int          t0    = 0;
    int          cyc   = 0;
    logic        m_we, m_err, m_uns;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, cap;

    // Expected outputs for the cycle following the latest rising edge.
    logic [1:0]  e_gnt, e_rv;
    logic        e_err, e_mwe, e_mload, e_muns, e_rd_chk;
    logic [1:0]  e_msize;
    logic [31:0] e_maddr, e_mwdata, e_rdata;

    initial begin : p_model
      int n;
      int k;
      forever begin
        @(posedge clk);
        n   = cyc;
        cyc = cyc + 1;
        if (rst[gi]) begin
          busy = 1'b0; last = 1'b1; sel = 1'b0; cap = '0;
          e_gnt = 2'b00; e_rv = 2'b00; e_err = 1'b0; e_mwe = 1'b0; e_mload = 1'b0;
          e_msize = '0; e_muns = 1'b0; e_maddr = '0; e_mwdata = '0;
          e_rdata = '0; e_rd_chk = 1'b1;
          armed = 1'b1;
        end else begin
          e_gnt = 2'b00; e_rv = 2'b00; e_err = 1'b0; e_mwe = 1'b0; e_mload = 1'b0;
          e_rd_chk = 1'b0;
          // A transaction occupies AC+2 cycles from its grant edge.
          if (busy && (n - t0) >= AC + 2) begin
            busy = 1'b0;
            last = sel;
          end
          if (!busy && (req[gi][0] || req[gi][1])) begin
            sel     = (req[gi][0] && req[gi][1]) ? !last : req[gi][1];
            m_we    = we_in[gi][sel];
            m_size  = size_in[gi][sel];
            m_uns   = uns_in[gi][sel];
            m_addr  = addr_in[gi][sel];
            m_wdata = wdata_in[gi][sel];
            m_err   = (m_size == 2'd3) || ((m_addr % (32'd1 << m_size)) != 0);
            busy    = 1'b1;
            t0      = n;
          end
          if (busy) begin
            k = n + 1 - t0;  // offset of the next cycle from the grant edge
            if (k == 1) begin
              e_gnt[sel] = 1'b1;
              e_msize = m_size; e_muns = m_uns; e_maddr = m_addr; e_mwdata = m_wdata;
            end
            if (k >= 1 && k <= AC) begin
              e_mload = !m_we && !m_err;
              e_mwe   = (k == AC) && m_we && !m_err;
            end
            if (k == AC + 1) cap = (m_we || m_err) ? 32'h0 : mem_rdata[gi];
            if (k == AC + 2) begin
              e_rv[sel] = 1'b1;
              e_err     = m_err;
              e_rdata   = cap;
              e_rd_chk  = 1'b1;
            end
          end
        end
      end
    end

    initial begin : p_compare
      forever begin
        @(negedge clk);
        if (armed) begin
          chk(gi, "gnt0",   gnt[gi][0], e_gnt[0]);
          chk(gi, "gnt1",   gnt[gi][1], e_gnt[1]);
          chk(gi, "rvalid0", rv[gi][0], e_rv[0]);
          chk(gi, "rvalid1", rv[gi][1], e_rv[1]);
          chk(gi, "err",    err[gi],    e_err);
          chk(gi, "mem_we", mwe[gi],    e_mwe);
          chk(gi, "mem_load", mload[gi], e_mload);
          chk(gi, "mem_size", msize[gi], e_msize);
          chk(gi, "mem_uns",  muns[gi],  e_muns);
          chk(gi, "mem_addr", maddr[gi], e_maddr);
          chk(gi, "mem_wdata", mwdata[gi], e_mwdata);
          if (e_rd_chk) chk(gi, "rdata", rdata[gi], e_rdata);
        end
      end
    end

    // Memory read data: random every cycle unless pinned by a directed test.
    initial begin : p_mem
      forever begin
        @(negedge clk);
        mem_rdata[gi] = rd_fixed[gi] ? rd_val[gi] : $urandom;
      end
    end
  end

  // One complete transaction on instance k / requester r, with latencies
  // counted in cycles from the cycle the request is raised.
  task automatic xact(input int k, input int r, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d,
                      output int glat, output int rlat, output logic [31:0] rd,
                      output logic e, output int wcnt, output int wlat,
                      output logic [31:0] waddr, output logic [1:0] wsize,
                      output logic [31:0] wdat);
    glat = -1; rlat = -1; rd = '0; e = 1'b0; wcnt = 0; wlat = -1;
    waddr = '0; wsize = '0; wdat = '0;
    @(negedge clk);
    req[k][r] = 1'b1; we_in[k][r] = w; size_in[k][r] = sz; uns_in[k][r] = 1'b0;
    addr_in[k][r] = a; wdata_in[k][r] = d;
    for (int n = 1; n <= 40 && rlat < 0; n++) begin
      @(negedge clk);
      if (gnt[k][r] && glat < 0) begin
        glat = n;
        req[k][r] = 1'b0;
      end
      if (mwe[k]) begin
        wcnt++; wlat = n; waddr = maddr[k]; wsize = msize[k]; wdat = mwdata[k];
      end
      if (rv[k][r]) begin
        rlat = n; rd = rdata[k]; e = err[k];
      end
    end
    req[k][r] = 1'b0;
  endtask

  // Random requester: raises requests with random payloads, sometimes
  // withdraws before grant, and keeps the payload stable until granted.
  task automatic rand_req(input int k, input int r, input int ncyc);
    bit holding = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (holding && gnt[k][r]) begin
        holding = 1'b0;
        req[k][r] = 1'b0;
      end
      if (holding && $urandom_range(0, 15) == 0) begin
        holding = 1'b0;
        req[k][r] = 1'b0;
      end else if (!holding && $urandom_range(0, 2) == 0) begin
        we_in[k][r]    = 1'($urandom_range(0, 1));
        size_in[k][r]  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        uns_in[k][r]   = 1'($urandom_range(0, 1));
        addr_in[k][r]  = 32'h10000 + 32'($urandom_range(0, 15));
        wdata_in[k][r] = $urandom;
        req[k][r]      = 1'b1;
        holding        = 1'b1;
      end
    end
    req[k][r] = 1'b0;
  endtask

  task automatic rand_rst(input int k, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (rst[k]) rst[k] = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst[k] = 1'b1;
    end
    rst[k] = 1'b0;
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int          glat, rlat, wcnt, wlat, nrv, nwe, tmo;
    logic [31:0] rd, waddr, wdat;
    logic [1:0]  wsize;
    logic        e;
    int          order[$];
    int          exp_ord[4];

    exp_ord = '{0, 1, 0, 1};
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; rd_fixed[k] = 1'b0; rd_val[k] = '0; mem_rdata[k] = '0;
      for (int r = 0; r < 2; r++) begin
        req[k][r] = 1'b0; we_in[k][r] = 1'b0; size_in[k][r] = '0; uns_in[k][r] = 1'b0;
        addr_in[k][r] = '0; wdata_in[k][r] = '0;
      end
    end
    repeat (3) @(negedge clk);
    chk(0, "reset_gnt0", gnt[0][0], 1'b0);
    chk(0, "reset_rdata", rdata[0], 32'h0);
    chk(1, "reset_mem_addr", maddr[1], 32'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // 1: uncontended load word
    rd_fixed[0] = 1'b1; rd_val[0] = 32'hDEADBEEF;
    xact(0, 0, 1'b0, 2'b10, 32'h10000, 32'h0, glat, rlat, rd, e, wcnt, wlat, waddr, wsize, wdat);
    chk(0, "t1_model_rdata", g_dut[0].e_rdata, 32'hDEADBEEF);
    chk(0, "t1_gnt_latency", glat, 1);
    chk(0, "t1_rv_latency", rlat, 3);
    chk(0, "t1_rdata", rd, 32'hDEADBEEF);
    chk(0, "t1_err", e, 1'b0);
    chk(0, "t1_no_strobe", wcnt, 0);
    rd_fixed[0] = 1'b0;

    // 2: store byte from requester 1
    xact(0, 1, 1'b1, 2'b00, 32'h10003, 32'h000000A5, glat, rlat, rd, e, wcnt, wlat, waddr, wsize, wdat);
    chk(0, "t2_strobe_count", wcnt, 1);
    chk(0, "t2_strobe_cycle", wlat, 1);
    chk(0, "t2_strobe_addr", waddr, 32'h10003);
    chk(0, "t2_strobe_size", wsize, 2'b00);
    chk(0, "t2_strobe_data", wdat[7:0], 8'hA5);
    chk(0, "t2_rv_latency", rlat, 3);
    chk(0, "t2_rdata", rd, 32'h0);

    // 3: both requesters held high, grants must alternate starting with 0
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      we_in[0][r] = 1'b0; size_in[0][r] = 2'b10; addr_in[0][r] = 32'h10010 + 32'(r * 16);
      req[0][r] = 1'b1;
    end
    for (int n = 0; n < 80 && order.size() < 4; n++) begin
      @(negedge clk);
      if (gnt[0][0]) order.push_back(0);
      if (gnt[0][1]) order.push_back(1);
    end
    req[0][0] = 1'b0;
    req[0][1] = 1'b0;
    chk(0, "t3_grant_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk(0, "t3_grant_order", order[i], exp_ord[i]);
    repeat (8) @(negedge clk);

    // 4: misaligned half store, reserved-size load
    xact(0, 0, 1'b1, 2'b01, 32'h10001, 32'h0000BEEF, glat, rlat, rd, e, wcnt, wlat, waddr, wsize, wdat);
    chk(0, "t4_half_err", e, 1'b1);
    chk(0, "t4_half_rdata", rd, 32'h0);
    chk(0, "t4_half_no_strobe", wcnt, 0);
    chk(0, "t4_half_rv_latency", rlat, 3);
    xact(0, 1, 1'b0, 2'b11, 32'h10000, 32'h0, glat, rlat, rd, e, wcnt, wlat, waddr, wsize, wdat);
    chk(0, "t4_size3_err", e, 1'b1);
    chk(0, "t4_size3_rdata", rd, 32'h0);

    // 5: ACCESS_CYCLES=3 store word
    xact(1, 0, 1'b1, 2'b10, 32'h10004, 32'h12345678, glat, rlat, rd, e, wcnt, wlat, waddr, wsize, wdat);
    chk(1, "t5_gnt_latency", glat, 1);
    chk(1, "t5_strobe_count", wcnt, 1);
    chk(1, "t5_strobe_cycle", wlat, 3);
    chk(1, "t5_strobe_data", wdat, 32'h12345678);
    chk(1, "t5_rv_latency", rlat, 5);
    chk(1, "t5_err", e, 1'b0);

    // 6: reset during BUSY of a store aborts it
    @(negedge clk);
    req[1][1] = 1'b1; we_in[1][1] = 1'b1; size_in[1][1] = 2'b10;
    addr_in[1][1] = 32'h10008; wdata_in[1][1] = 32'hCAFEF00D;
    tmo = 1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (gnt[1][1]) begin
        tmo = 0;
        break;
      end
    end
    chk(1, "t6_grant_seen", tmo, 0);
    req[1][1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    chk(1, "t6_strobe_after_rst", mwe[1], 1'b0);
    chk(1, "t6_addr_after_rst", maddr[1], 32'h0);
    chk(1, "t6_wdata_after_rst", mwdata[1], 32'h0);
    nrv = 0; nwe = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (rv[1][0] || rv[1][1]) nrv++;
      if (mwe[1]) nwe++;
    end
    chk(1, "t6_no_rvalid", nrv, 0);
    chk(1, "t6_no_strobe", nwe, 0);
    xact(1, 1, 1'b1, 2'b10, 32'h10008, 32'hCAFEF00D, glat, rlat, rd, e, wcnt, wlat, waddr, wsize, wdat);
    chk(1, "t6_retry_strobe", wcnt, 1);
    chk(1, "t6_retry_addr", waddr, 32'h10008);
    chk(1, "t6_retry_rv_latency", rlat, 5);
    chk(1, "t6_retry_err", e, 1'b0);

    // Randomized phase: both instances, both requesters, occasional resets
    fork
      rand_req(0, 0, 3000);
      rand_req(0, 1, 3000);
      rand_req(1, 0, 3000);
      rand_req(1, 1, 3000);
      rand_rst(0, 3000);
      rand_rst(1, 3000);
    join
    repeat (12) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: requester 0 is the pipeline memory stage; requester 1 is the loader/DMA port that fills memory.
- Arbitrates round-robin and sequences each access over a fixed number of cycles.
- Drives a registered memory-side interface and returns read data or a write-completion acknowledgement to the granted requester.
- Sits between the memory stage / loader and the byte-addressable data memory, which writes on the falling clock edge.

Parameters:
DATA_WIDTH, 32, data bus width in bits.
ACCESS_CYCLES, 1, memory-side cycles per transaction; legal range 1 to 15.

Ports:
iClk  in  1  clock; all state updates on the rising edge.
iRst  in  1  synchronous active-high reset.
iReq0 / iReq1  in  1  access request from requester 0 / 1.
iWe0 / iWe1  in  1  1 = store, 0 = load.
iSize0 / iSize1  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
iUns0 / iUns1  in  1  zero-extend a load (ignored for stores).
iAddr0 / iAddr1  in  32  byte address.
iWData0 / iWData1  in  DATA_WIDTH  store data, right-aligned.
oGnt0 / oGnt1  out  1  one-cycle pulse: request accepted, payload latched.
oRValid0 / oRValid1  out  1  one-cycle pulse: transaction complete.
oRData  out  DATA_WIDTH  load result; valid only while an oRValid is high.
oErr  out  1  accompanies oRValid when the access was misaligned or used a reserved size.
oMemWriteEn  out  1  memory write strobe, registered.
oMemLoad  out  1  memory read-access flag, registered.
oMemSize  out  2  latched size.
oMemUns  out  1  latched unsigned flag.
oMemAddr  out  32  latched address.
oMemWData  out  DATA_WIDTH  latched store data.
iMemRData  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset: state IDLE; every output 0; access counter 0; round-robin pointer set to prefer requester 0. Reset mid-transaction aborts it: no write strobe, no oRValid, and the requester must re-request.
- States:
  - IDLE: if any iReq is high, select one. If both are high, select the requester not served last. Latch its payload; pulse its oGnt in the next cycle; check alignment; go to BUSY with counter = ACCESS_CYCLES-1. No request: stay in IDLE.
  - BUSY: drive the oMem* outputs from the latched payload. Decrement the counter each cycle. oMemWriteEn is high only in the final BUSY cycle (counter==0), and only for aligned, legal stores. This guarantees exactly one falling-edge commit.
  - DONE: at the rising edge ending the final BUSY cycle, capture iMemRData into oRData for loads (0 for stores or errors). Pulse the matching oRValid for one cycle with oErr. Update the pointer to the served requester. Clear oMemWriteEn and oMemLoad. Return to IDLE.
- Throughput: one transaction per ACCESS_CYCLES+2 cycles; there is no back-to-back issue from DONE.
- Latency: request to oRValid is ACCESS_CYCLES+2 cycles for an uncontended request.
- Handshake:
  - The requester holds iReq and its payload stable until oGnt.
  - The payload may change after oGnt.
  - The requester may drop iReq before grant (withdrawal), which has no effect.
  - A new request from the same requester may be raised in the oRValid cycle.
- Alignment:
  - half: addr[0] must be 0.
  - word: addr[1:0] must be 00.
  - Size 11 is an error.
  - On error: the BUSY phase still runs for timing, with no write; oRData = 0 and oErr = 1.
- Fairness: with both requesters continuously requesting, grants alternate strictly. A requester waits at most one foreign transaction.
- Requests arriving during BUSY/DONE are ignored until IDLE. Requests are not queued.
- oGnt0 and oGnt1 are never high in the same cycle. At most one oRValid is high per cycle.

Test Plan:
1. Reset, then iReq0 load word at 0x10000 with memory returning 0xDEADBEEF (ACCESS_CYCLES=1) -> oGnt0 is 1 cycle after the request; oRValid0 is 3 cycles after the request with oRData=0xDEADBEEF and oErr=0; oMemWriteEn stays 0.
2. iReq1 store byte 0xA5 to 0x10003 -> oMemWriteEn high for exactly one cycle with oMemAddr=0x10003, oMemSize=00 and oMemWData[7:0]=0xA5; oRValid1 follows with oRData=0.
3. iReq0 and iReq1 held high together for 4 transactions -> grant order 0,1,0,1; no overlap between transactions.
4. Store half to 0x10001 -> no write strobe; oRValid with oErr=1 and oRData=0. Load with size 11 -> oErr=1.
5. ACCESS_CYCLES=3, store word 0x12345678 -> oMem* outputs stable for 3 cycles; write strobe only in the third cycle; oRValid at cycle 5 after the request.
6. Assert iRst during BUSY of a store -> no write strobe, all outputs 0 on the next cycle; re-request completes normally.
